mem_data_arbiter: RTL

//  Shares the single-port synchronous data RAM between two load/store requesters:

---
 rtl/mem_data_pkg.sv | 47 ++++
 rtl/mem_data_lane_fmt.sv | 28 ++
 rtl/mem_data_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_data_pkg.sv
// Shared types and helpers for the data-RAM arbiter.
package mem_data_pkg;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WAIT   = 2'b10,
        RESP   = 2'b11
    } state_e;

    typedef struct packed {
        logic        load;
        logic        store;
        logic        sgn;
        logic [1:0]  ls_type;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Byte-lane write enables for a store of the given size at byte offset lo.
    function automatic logic [3:0] we_mask(input logic [1:0] ls_type, input logic [1:0] lo);
        logic [3:0] m;
        case (ls_type)
            LS_BYTE: m = 4'b0001 << lo;
            LS_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
            LS_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate right-aligned store data across every lane it may land in.
    function automatic logic [31:0] store_lanes(input logic [1:0] ls_type, input logic [31:0] wdata);
        logic [31:0] d;
        case (ls_type)
            LS_BYTE: d = {4{wdata[7:0]}};
            LS_HALF: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_data_lane_fmt.sv
// Load-data formatter: picks the addressed lane and sign/zero extends it.
module mem_data_lane_fmt
    import mem_data_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  ls_type,
    input  logic        sgn,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select followed by extension.
    always_comb begin
        byte_v = 8'(rdata >> {addr_lo, 3'b000});
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        data   = '0;
        case (ls_type)
            LS_BYTE: data = {{24{sgn & byte_v[7]}}, byte_v};
            LS_HALF: data = {{16{sgn & half_v[15]}}, half_v};
            LS_WORD: data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_data_arbiter.sv
// Two-port load/store arbiter in front of a single-port synchronous data RAM.
module mem_data_arbiter
    import mem_data_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              io_req0_valid,
    output logic              io_req0_ready,
    input  logic              io_req0_load,
    input  logic              io_req0_store,
    input  logic              io_req0_signed,
    input  logic [1:0]        io_req0_lsType,
    input  logic [31:0]       io_req0_addr,
    input  logic [31:0]       io_req0_wdata,
    input  logic              io_req1_valid,
    output logic              io_req1_ready,
    input  logic              io_req1_load,
    input  logic              io_req1_store,
    input  logic              io_req1_signed,
    input  logic [1:0]        io_req1_lsType,
    input  logic [31:0]       io_req1_addr,
    input  logic [31:0]       io_req1_wdata,
    output logic              io_rsp0_valid,
    input  logic              io_rsp0_ready,
    output logic [31:0]       io_rsp0_data,
    output logic              io_rsp0_err,
    output logic              io_rsp1_valid,
    input  logic              io_rsp1_ready,
    output logic [31:0]       io_rsp1_data,
    output logic              io_rsp1_err,
    output logic              io_mem_en,
    output logic [3:0]        io_mem_we,
    output logic [ADDR_W-1:0] io_mem_addr,
    output logic [31:0]       io_mem_wdata,
    input  logic [31:0]       io_mem_rdata
);

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               prio_q, prio_d;
    logic               ld_q, ld_d;
    logic               sgn_q, sgn_d;
    logic [1:0]         ls_q, ls_d;
    logic [1:0]         lo_q, lo_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic [1:0]         rsp_err_q, rsp_err_d;
    logic [1:0][31:0]   rsp_data_q, rsp_data_d;
    logic               mem_en_q, mem_en_d;
    logic [3:0]         mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    mem_req_t           req0, req1, sel;
    logic               idle, grant, accept, sel_bad;
    logic [1:0]         rsp_ready;
    logic [31:0]        fmt_data;

    // Malformed, misaligned or out-of-range requests never reach the RAM.
    function automatic logic req_bad(input mem_req_t r);
        logic bad;
        bad = (r.load == r.store)
            || (r.ls_type == 2'b11)
            || ((r.ls_type == LS_HALF) && r.addr[0])
            || ((r.ls_type == LS_WORD) && (r.addr[1:0] != 2'b00))
            || ((r.addr >> (ADDR_W + 2)) != 32'd0);
        return bad;
    endfunction

    assign req0 = '{load: io_req0_load, store: io_req0_store, sgn: io_req0_signed,
                    ls_type: io_req0_lsType, addr: io_req0_addr, wdata: io_req0_wdata};
    assign req1 = '{load: io_req1_load, store: io_req1_store, sgn: io_req1_signed,
                    ls_type: io_req1_lsType, addr: io_req1_addr, wdata: io_req1_wdata};

    // Arbitration: a lone requester wins; a tie goes to the rr pointer or to port 0.
    assign idle          = (state_q == IDLE) && reset_n;
    assign grant         = (io_req0_valid && io_req1_valid) ? (RR_EN ? prio_q : 1'b0)
                                                            : io_req1_valid;
    assign io_req0_ready = idle && io_req0_valid && !grant;
    assign io_req1_ready = idle && io_req1_valid && grant;
    assign accept        = io_req0_ready || io_req1_ready;
    assign sel           = grant ? req1 : req0;
    assign sel_bad       = req_bad(sel);
    assign rsp_ready     = {io_rsp1_ready, io_rsp0_ready};

    mem_data_lane_fmt u_fmt (
        .rdata   (io_mem_rdata),
        .addr_lo (lo_q),
        .ls_type (ls_q),
        .sgn     (sgn_q),
        .data    (fmt_data)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        ld_d        = ld_q;
        sgn_d       = sgn_q;
        ls_d        = ls_q;
        lo_d        = lo_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 4'b0000;
        mem_addr_d  = '0;
        mem_wdata_d = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = grant;
                    prio_d  = ~grant;
                    ld_d    = sel.load;
                    sgn_d   = sel.sgn;
                    ls_d    = sel.ls_type;
                    lo_d    = sel.addr[1:0];
                    if (sel_bad) begin
                        state_d                = RESP;
                        rsp_valid_d[grant]     = 1'b1;
                        rsp_err_d[grant]       = 1'b1;
                        rsp_data_d[grant]      = '0;
                    end else begin
                        state_d    = ACCESS;
                        mem_en_d   = 1'b1;
                        mem_addr_d = sel.addr[ADDR_W+1:2];
                        if (sel.store) begin
                            mem_we_d    = we_mask(sel.ls_type, sel.addr[1:0]);
                            mem_wdata_d = store_lanes(sel.ls_type, sel.wdata);
                        end
                    end
                end
            end
            ACCESS: begin
                if (ld_q) begin
                    state_d = WAIT;
                end else begin
                    state_d              = RESP;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d[owner_q]   = 1'b0;
                    rsp_data_d[owner_q]  = '0;
                end
            end
            WAIT: begin
                state_d              = RESP;
                rsp_valid_d[owner_q] = 1'b1;
                rsp_err_d[owner_q]   = 1'b0;
                rsp_data_d[owner_q]  = fmt_data;
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d     = IDLE;
                    rsp_valid_d = 2'b00;
                    rsp_err_d   = 2'b00;
                    rsp_data_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            prio_q      <= 1'b0;
            ld_q        <= 1'b0;
            sgn_q       <= 1'b0;
            ls_q        <= 2'b00;
            lo_q        <= 2'b00;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 2'b00;
            rsp_data_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            prio_q      <= prio_d;
            ld_q        <= ld_d;
            sgn_q       <= sgn_d;
            ls_q        <= ls_d;
            lo_q        <= lo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign io_rsp0_valid = rsp_valid_q[0];
    assign io_rsp1_valid = rsp_valid_q[1];
    assign io_rsp0_err   = rsp_err_q[0];
    assign io_rsp1_err   = rsp_err_q[1];
    assign io_rsp0_data  = rsp_data_q[0];
    assign io_rsp1_data  = rsp_data_q[1];
    assign io_mem_en     = mem_en_q;
    assign io_mem_we     = mem_we_q;
    assign io_mem_addr   = mem_addr_q;
    assign io_mem_wdata  = mem_wdata_q;

endmodule
